dac_pair_sequencer: RTL and testbench

- Sequences one dual-channel (I/Q) 10-bit DAC port in interleaved pin mode.
- Handles the power-up/power-down sequence on the DAC control pins.
- Pulls I/Q sample pairs from a valid/ready stream and time-multiplexes them onto the shared data bus, with DCLKIO marking the channel.
- Sits between the sample source and the DAC pins: one instance per DAC, clocked from the derived 50 MHz system clock.

---
 rtl/dac_pair_sequencer_if.sv | 11 +
 rtl/dac_pair_sequencer.sv | 154 +++++++++++++++
 tb/tb_dac_pair_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_pair_sequencer_if.sv
// I/Q sample-pair stream feeding the DAC pair sequencer.
// The master presents a pair with s_valid; the sequencer raises s_ready on the cycle it accepts it.
interface dac_pair_sequencer_if;
    logic [9:0] s_i;
    logic [9:0] s_q;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_i, output s_q, output s_valid, input s_ready);
    modport slave  (input s_i, input s_q, input s_valid, output s_ready);
endinterface

// File: rtl/dac_pair_sequencer.sv
// Power sequencing and I/Q interleaving for one dual-channel 10-bit DAC port.
// state | meaning: OFF powered down | WAKE power-up wait | RUN streaming pairs | STOP flush one idle pair
module dac_pair_sequencer #(
    parameter int PWRUP_CYCLES = 100,
    parameter bit TWOS_IN      = 1'b1,
    parameter bit PINMD_VAL    = 1'b1,
    parameter bit CLKMD_VAL    = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [7:0]                  rate_div,
    dac_pair_sequencer_if.slave         s,
    output logic [9:0]                  dac_data,
    output logic                        dac_dclkio,
    output logic                        dac_pwrdn,
    output logic                        dac_open_i,
    output logic                        dac_open_q,
    output logic                        dac_pinmd,
    output logic                        dac_clkmd,
    output logic                        dac_format,
    output logic                        underflow,
    output logic [15:0]                 uf_count,
    input  logic                        uf_clr,
    output logic [1:0]                  state_o
);

    localparam logic [9:0] MID = 10'h200;
    localparam int WW = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
    localparam logic [WW-1:0] WAKE_LOAD = WW'(PWRUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t        state;
    logic [WW-1:0] wake_cnt;
    logic [7:0]    cnt;
    logic [7:0]    rate_q;
    logic          ph;
    logic [9:0]    q_hold;
    logic          slot_end;
    logic          fetch;

    function automatic logic [9:0] conv(input logic [9:0] x);
        conv = TWOS_IN ? {~x[9], x[8:0]} : x;
    endfunction

    assign slot_end  = (cnt == rate_q);
    assign fetch     = (state == ST_RUN) && slot_end && ph;
    assign s.s_ready = fetch && en;

    assign dac_pwrdn  = (state == ST_OFF);
    assign dac_open_i = (state == ST_RUN) || (state == ST_STOP);
    assign dac_open_q = (state == ST_RUN) || (state == ST_STOP);
    assign dac_pinmd  = PINMD_VAL;
    assign dac_clkmd  = CLKMD_VAL;
    assign dac_format = 1'b0;
    assign state_o    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_OFF;
            wake_cnt   <= '0;
            cnt        <= 8'd0;
            rate_q     <= 8'd0;
            ph         <= 1'b1;
            q_hold     <= MID;
            dac_data   <= MID;
            dac_dclkio <= 1'b0;
            underflow  <= 1'b0;
            uf_count   <= 16'd0;
        end else begin
            underflow <= 1'b0;
            // clear wins over a same-cycle underflow increment
            if (uf_clr)
                uf_count <= 16'd0;
            else if (fetch && en && !s.s_valid && (uf_count != 16'hFFFF))
                uf_count <= uf_count + 16'd1;

            unique case (state)
                ST_OFF: begin
                    dac_data   <= MID;
                    dac_dclkio <= 1'b0;
                    cnt        <= 8'd0;
                    ph         <= 1'b1;
                    if (en) begin
                        state    <= ST_WAKE;
                        wake_cnt <= WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (!en) begin
                        state    <= ST_OFF;
                        wake_cnt <= '0;
                    end else if (wake_cnt == '0) begin
                        // enter RUN sitting on the last Q clock so the first cycle fetches
                        state  <= ST_RUN;
                        cnt    <= rate_div;
                        rate_q <= rate_div;
                        ph     <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (slot_end) begin
                        cnt <= 8'd0;
                        if (ph) begin
                            ph         <= 1'b0;
                            dac_dclkio <= 1'b1;
                            dac_data   <= MID;
                            if (en) begin
                                rate_q <= rate_div;
                                if (s.s_valid) begin
                                    dac_data <= conv(s.s_i);
                                    q_hold   <= conv(s.s_q);
                                end else begin
                                    q_hold    <= MID;
                                    underflow <= 1'b1;
                                end
                            end else begin
                                state <= ST_STOP;
                            end
                        end else begin
                            ph         <= 1'b1;
                            dac_dclkio <= 1'b0;
                            dac_data   <= q_hold;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_STOP: begin
                    dac_data <= MID;
                    if (slot_end) begin
                        cnt        <= 8'd0;
                        ph         <= 1'b1;
                        dac_dclkio <= 1'b0;
                        if (ph)
                            state <= ST_OFF;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_pair_sequencer.sv
// Scoreboard bench for dac_pair_sequencer: each fetch cycle queues the expected slot
// contents, which are then compared clock by clock on the falling edge.
module tb_dac_pair_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        uf_clr = 1'b0;
    logic [7:0]  rate_div = 8'd1;
    logic [9:0]  dac_data;
    logic        dac_dclkio, dac_pwrdn, dac_open_i, dac_open_q;
    logic        dac_pinmd, dac_clkmd, dac_format, underflow;
    logic [15:0] uf_count;
    logic [1:0]  state_o;

    dac_pair_sequencer_if sif ();

    dac_pair_sequencer #(.PWRUP_CYCLES(4), .TWOS_IN(1'b1), .PINMD_VAL(1'b1), .CLKMD_VAL(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .rate_div(rate_div), .s(sif.slave),
        .dac_data(dac_data), .dac_dclkio(dac_dclkio), .dac_pwrdn(dac_pwrdn),
        .dac_open_i(dac_open_i), .dac_open_q(dac_open_q), .dac_pinmd(dac_pinmd),
        .dac_clkmd(dac_clkmd), .dac_format(dac_format), .underflow(underflow),
        .uf_count(uf_count), .uf_clr(uf_clr), .state_o(state_o)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [9:0] data;
        logic       dclk;
        logic [1:0] st;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          acc_cnt = 0;
    logic [15:0] uf_model = 16'd0;
    logic        exp_uf = 1'b0;
    logic        stop_pending = 1'b0;
    logic        exp_off = 1'b0;
    logic        stop_done = 1'b0;
    logic        mon_arm = 1'b0;
    logic [9:0]  pi [16];
    logic [9:0]  pq [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] cv(input logic [9:0] x);
        return x ^ 10'h200;
    endfunction

    task automatic push_pair(input logic [9:0] di, input logic [9:0] dq, input logic [1:0] st);
        for (int k = 0; k <= int'(rate_div); k++) sb.push_back('{di, 1'b1, st});
        for (int k = 0; k <= int'(rate_div); k++) sb.push_back('{dq, 1'b0, st});
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic uf_evt;
        uf_evt = 1'b0;
        if (!rst) begin
            sb.delete();
            stop_pending = 1'b0;
            exp_off = 1'b0;
            exp_uf = 1'b0;
            uf_model = 16'd0;
            stop_done = 1'b0;
        end else begin
            chk("underflow", underflow, exp_uf);
            exp_uf = 1'b0;
            chk("uf_count", uf_count, uf_model);
            if (!mon_arm) begin
                stop_done = 1'b0;
            end else if (!stop_done) begin
                if (exp_off) begin
                    chk("off_state", state_o, 2'd0);
                    chk("off_pwrdn", dac_pwrdn, 1'b1);
                    chk("off_open", {dac_open_i, dac_open_q}, 2'b00);
                    exp_off = 1'b0;
                    stop_done = 1'b1;
                end else begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("data", dac_data, e.data);
                        chk("dclkio", dac_dclkio, e.dclk);
                        chk("state", state_o, e.st);
                        chk("open", {dac_open_i, dac_open_q}, 2'b11);
                        chk("pwrdn", dac_pwrdn, 1'b0);
                    end
                    if (sb.size() > 0) begin
                        chk("s_ready_idle", sif.s_ready, 1'b0);
                    end else if (stop_pending) begin
                        exp_off = 1'b1;
                        stop_pending = 1'b0;
                    end else begin
                        chk("s_ready_fetch", sif.s_ready, en);
                        chk("fetch_state", state_o, 2'd2);
                        if (en && sif.s_valid) begin
                            push_pair(cv(sif.s_i), cv(sif.s_q), 2'd2);
                            acc_cnt++;
                        end else if (en) begin
                            push_pair(10'h200, 10'h200, 2'd2);
                            exp_uf = 1'b1;
                            uf_evt = 1'b1;
                        end else begin
                            push_pair(10'h200, 10'h200, 2'd3);
                            stop_pending = 1'b1;
                        end
                    end
                end
            end
            if (uf_clr) uf_model = 16'd0;
            else if (uf_evt && uf_model != 16'hFFFF) uf_model = uf_model + 16'd1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sif.s_i = pi[acc_cnt % 16];
            sif.s_q = pq[acc_cnt % 16];
        end
    endtask

    // Called one step after a rising edge with the DUT in OFF.
    task automatic wake_seq();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("wake_state", state_o, 2'd1);
            chk("wake_pwrdn", dac_pwrdn, 1'b0);
            chk("wake_ready", sif.s_ready, 1'b0);
        end
        cyc(1);
        chk("run_entry", state_o, 2'd2);
        mon_arm = 1'b1;
    endtask

    task automatic wait_slot(input logic want_dclk);
        for (int k = 0; k < 64; k++) begin
            if (sb.size() > 0 && sb[0].dclk == want_dclk && sb[0].st == 2'd2) break;
            cyc(1);
        end
    endtask

    task automatic wait_stop();
        for (int k = 0; k < 200; k++) begin
            if (stop_done) break;
            cyc(1);
        end
        chk("stop_reached", stop_done, 1'b1);
        mon_arm = 1'b0;
    endtask

    initial begin
        pi[0] = 10'h000; pq[0] = 10'h1FF;
        pi[1] = 10'h200; pq[1] = 10'h07F;
        for (int k = 2; k < 16; k++) begin
            pi[k] = 10'($urandom_range(0, 1023));
            pq[k] = 10'($urandom_range(0, 1023));
        end
        sif.s_i = pi[0];
        sif.s_q = pq[0];
        sif.s_valid = 1'b1;

        #5 rst = 1'b0;
        #1;
        chk("rst_state", state_o, 2'd0);
        chk("rst_data", dac_data, 10'h200);
        chk("rst_dclkio", dac_dclkio, 1'b0);
        chk("rst_ready", sif.s_ready, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_uf_count", uf_count, 16'd0);
        chk("rst_pwrdn", dac_pwrdn, 1'b1);
        chk("rst_open", {dac_open_i, dac_open_q}, 2'b00);
        chk("pins_const", {dac_pinmd, dac_clkmd, dac_format}, 3'b100);

        cyc(2);
        rst = 1'b1;
        wake_seq();
        cyc(18);

        // slot length change in the middle of a pair
        wait_slot(1'b1);
        rate_div = 8'd3;
        cyc(20);

        rate_div = 8'd0;
        sif.s_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (uf_model >= 16'd3) break;
            cyc(1);
        end
        chk("uf_count_3", uf_count, 16'd3);
        uf_clr = 1'b1;
        cyc(2);
        uf_clr = 1'b0;
        chk("uf_clr_prio", uf_count, 16'd0);
        sif.s_valid = 1'b1;
        cyc(8);

        rate_div = 8'd2;
        cyc(8);
        wait_slot(1'b1);
        en = 1'b0;
        wait_stop();
        cyc(2);

        wake_seq();
        cyc(6);
        wait_slot(1'b0);
        rst = 1'b0;
        mon_arm = 1'b0;
        #1;
        chk("arst_pwrdn", dac_pwrdn, 1'b1);
        chk("arst_data", dac_data, 10'h200);
        chk("arst_state", state_o, 2'd0);
        cyc(2);
        rst = 1'b1;
        wake_seq();
        cyc(12);
        en = 1'b0;
        wait_stop();
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
